// File: rtl/private_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | private_bus_arbiter: round-robin sharer of the single-beat AXI-Lite      |
// | private bus. Optional watchdog: define PRIV_ARB_TIMEOUT_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module private_bus_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_start,
  input  logic [NUM_REQ-1:0]     req_type,
  input  logic [NUM_REQ-1:0]     req_abort,
  input  logic [32*NUM_REQ-1:0]  req_addr,
  input  logic [32*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [31:0]            req_rdata,
  output logic                   arb_busy,
  input  logic                   mem_ack_private,
  input  logic [31:0]            data_read_input_private,
  output logic                   start_burst_private,
  output logic                   burst_type_private,
  output logic [31:0]            address_write_private,
  output logic [31:0]            address_read_private,
  output logic [31:0]            data_write_private
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [NUM_REQ-1:0]       pend_q, pend_d;
  logic [NUM_REQ-1:0]       type_q;
  logic [NUM_REQ-1:0][31:0] addr_q;
  logic [NUM_REQ-1:0][31:0] wdata_q;
  logic [IW-1:0]            owner_q, owner_d;
  logic [IW-1:0]            rr_q, rr_d;
  logic                     aborted_q, aborted_d;
  logic [31:0]              rdata_q, rdata_d;

  logic [NUM_REQ-1:0]       cap;
  logic [NUM_REQ-1:0]       drop;
  logic [NUM_REQ-1:0]       elig;
  logic [NUM_REQ-1:0]       owner_oh;
  logic                     owner_active;
  logic                     sel_found;
  logic [IW-1:0]            sel_idx;
  logic [IW-1:0]            cand;
  logic                     tmo_hit;
  logic                     ack_en;
  logic                     beat_done;

  assign owner_active = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign beat_done    = (state_q == S_WAIT) && (mem_ack_private || tmo_hit);

  // The in-flight owner's slot is frozen: its beat cannot be cancelled or replaced.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      assign owner_oh[i] = (owner_q == IW'(i));
      assign cap[i]  = req_start[i] && (!pend_q[i] || req_abort[i]) &&
                       !(owner_active && owner_oh[i]);
      assign drop[i] = req_abort[i] && !req_start[i] &&
                       !(owner_active && owner_oh[i]);

      always_ff @(posedge clk) begin
        if (rst) begin
          type_q[i]  <= 1'b0;
          addr_q[i]  <= '0;
          wdata_q[i] <= '0;
        end else if (cap[i]) begin
          type_q[i]  <= req_type[i];
          addr_q[i]  <= req_addr[32*i +: 32];
          wdata_q[i] <= req_wdata[32*i +: 32];
        end
      end
    end
  endgenerate

  assign elig = pend_q & ~drop;

  always_comb begin
    pend_d = (pend_q | cap) & ~drop;
    if (beat_done) begin
      pend_d = pend_d & ~owner_oh;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(rr_q) + k) % NUM_REQ);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef PRIV_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] tmo_cnt_q;
  logic          err_q;

  assign tmo_hit = (state_q == S_WAIT) && !mem_ack_private &&
                   (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_q == S_ISSUE)) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_WAIT) && !tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      err_q <= tmo_hit;
    end
  end

  assign req_err = (ack_en && err_q) ? owner_oh : '0;
`else
  logic tmo_unused;

  assign tmo_unused = (TIMEOUT_CYCLES > 0);
  assign tmo_hit    = 1'b0;
  assign req_err    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (beat_done) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    rr_d      = rr_q;
    aborted_d = aborted_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          owner_d   = sel_idx;
          aborted_d = 1'b0;
        end
      end
      S_ISSUE: begin
        aborted_d = aborted_q | (|(req_abort & owner_oh));
      end
      S_WAIT: begin
        aborted_d = aborted_q | (|(req_abort & owner_oh));
        if (mem_ack_private) begin
          rdata_d = type_q[owner_q] ? 32'h0 : data_read_input_private;
        end else if (tmo_hit) begin
          rdata_d = 32'hDEAD_BEEF;
        end
      end
      S_RESP: begin
        rr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
      end
      default: begin
        owner_d = owner_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      aborted_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      pend_q    <= pend_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      aborted_q <= aborted_d;
      rdata_q   <= rdata_d;
    end
  end

  // An owner aborted mid-beat still passes through RESP but stays silent.
  assign ack_en = (state_q == S_RESP) && !aborted_q;

  always_comb begin
    start_burst_private   = 1'b0;
    burst_type_private    = 1'b0;
    address_write_private = '0;
    address_read_private  = '0;
    data_write_private    = '0;
    req_ack               = '0;
    req_rdata             = '0;
    arb_busy              = (|pend_q) || (state_q != S_IDLE);
    if (state_q == S_ISSUE) begin
      start_burst_private = 1'b1;
    end
    if (owner_active) begin
      burst_type_private    = type_q[owner_q];
      address_write_private = addr_q[owner_q];
      address_read_private  = addr_q[owner_q];
      data_write_private    = wdata_q[owner_q];
    end
    if (ack_en) begin
      req_ack   = owner_oh;
      req_rdata = rdata_q;
    end
  end

endmodule
`default_nettype wire
